// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: single-cycle ALU results take priority over a
// small FIFO of load results; a per-register scoreboard tracks pending loads.
module wb_arbiter #(
  parameter int DEPTH  = 4,
  parameter int STARVE = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_we,
  input  logic [4:0]  alu_wn,
  input  logic [31:0] alu_d,
  input  logic        ld_valid,
  input  logic [4:0]  ld_wn,
  input  logic [31:0] ld_d,
  output logic        ld_ready,
  output logic        we,
  output logic [4:0]  wn,
  output logic [31:0] d,
  output logic [31:0] busy,
  output logic        alu_stall,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]       fifo_wn [DEPTH];
  logic [31:0]      fifo_d  [DEPTH];
  logic [DEPTH-1:0] live_reg;
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [7:0]       starve_reg;

  logic push, pop, kill;

  assign ld_ready  = count_reg < CW'(DEPTH);
  assign push      = ld_valid && ld_ready;
  assign pop       = !alu_we && (count_reg != '0);
  assign kill      = alu_we && (alu_wn != 5'd0);
  assign alu_stall = (starve_reg >= 8'(STARVE)) || (count_reg >= CW'(DEPTH - 1));

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_wn[wr_ptr_reg] <= ld_wn;
      fifo_d[wr_ptr_reg]  <= ld_d;
    end
  end

  // Live bits: an entry pushed on the same edge as a matching ALU write is born dead.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_live
      always_ff @(posedge clk) begin
        if (rst)
          live_reg[gi] <= 1'b0;
        else if (push && wr_ptr_reg == AW'(gi))
          live_reg[gi] <= !(kill && ld_wn == alu_wn);
        else if (pop && rd_ptr_reg == AW'(gi))
          live_reg[gi] <= 1'b0;
        else if (kill && fifo_wn[gi] == alu_wn)
          live_reg[gi] <= 1'b0;
      end
    end

    for (gi = 0; gi < 32; gi++) begin : g_busy
      if (gi == 0) begin : g_zero
        assign busy[gi] = 1'b0;
      end else begin : g_reg
        logic hit;
        always_comb begin
          hit = 1'b0;
          for (int i = 0; i < DEPTH; i++)
            if (live_reg[i] && fifo_wn[i] == 5'(gi))
              hit = 1'b1;
        end
        assign busy[gi] = hit;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      starve_reg <= '0;
      we         <= 1'b0;
      wn         <= 5'd0;
      d          <= 32'd0;
      err        <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CW'(push) - CW'(pop);

      // Saturating so a long ALU burst can never wrap the counter back below STARVE.
      if (pop || count_reg == '0)
        starve_reg <= '0;
      else if (alu_we && starve_reg != 8'hFF)
        starve_reg <= starve_reg + 8'd1;

      if (alu_we && alu_stall)
        err <= 1'b1;

      if (alu_we) begin
        we <= (alu_wn != 5'd0);
        wn <= alu_wn;
        d  <= alu_d;
      end else if (pop) begin
        we <= live_reg[rd_ptr_reg] && (fifo_wn[rd_ptr_reg] != 5'd0);
        wn <= fifo_wn[rd_ptr_reg];
        d  <= fifo_d[rd_ptr_reg];
      end else begin
        we <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: queue-based reference model checked every cycle, plus
// literal expectations for the directed scenarios.
module tb_wb_arbiter;

  localparam int DEPTH  = 4;
  localparam int STARVE = 3;

  logic        clk = 1'b0;
  logic        rst, alu_we, ld_valid;
  logic [4:0]  alu_wn, ld_wn;
  logic [31:0] alu_d, ld_d;
  logic        ld_ready, we, alu_stall, err;
  logic [4:0]  wn;
  logic [31:0] d, busy;

  wb_arbiter #(.DEPTH(DEPTH), .STARVE(STARVE)) dut (
    .clk(clk), .rst(rst),
    .alu_we(alu_we), .alu_wn(alu_wn), .alu_d(alu_d),
    .ld_valid(ld_valid), .ld_wn(ld_wn), .ld_d(ld_d),
    .ld_ready(ld_ready), .we(we), .wn(wn), .d(d),
    .busy(busy), .alu_stall(alu_stall), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  wn;
    logic [31:0] d;
    bit          live;
  } ent_t;

  ent_t        q[$];
  int          m_starve;
  logic        m_we, m_err;
  logic [4:0]  m_wn;
  logic [31:0] m_d;
  bit          chk_en = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_busy();
    logic [31:0] b = '0;
    foreach (q[i]) if (q[i].live && q[i].wn != 0) b[q[i].wn] = 1'b1;
    return b;
  endfunction

  function automatic logic m_ready();
    return q.size() < DEPTH;
  endfunction

  function automatic logic m_stall();
    return (m_starve >= STARVE) || (q.size() >= DEPTH - 1);
  endfunction

  // Reference model: what the outputs must be after this edge, from the rules.
  task automatic model_step();
    bit   rdy, stall, popped;
    int   sz;
    ent_t e;
    if (rst) begin
      q.delete();
      m_starve = 0; m_we = 0; m_wn = 0; m_d = 0; m_err = 0;
      return;
    end
    rdy = m_ready(); stall = m_stall(); sz = q.size(); popped = 0;
    if (alu_we && stall) m_err = 1;
    if (alu_we) begin
      m_we = (alu_wn != 0); m_wn = alu_wn; m_d = alu_d;
    end else if (sz > 0) begin
      e = q.pop_front();
      m_we = e.live && (e.wn != 0); m_wn = e.wn; m_d = e.d; popped = 1;
    end else begin
      m_we = 0;
    end
    if (popped || sz == 0) m_starve = 0;
    else if (alu_we) m_starve++;
    if (ld_valid && rdy) q.push_back('{wn: ld_wn, d: ld_d, live: 1'b1});
    if (alu_we && alu_wn != 0)
      foreach (q[i]) if (q[i].wn == alu_wn) q[i].live = 0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("we",        {31'd0, we},        {31'd0, m_we});
      chk("wn",        {27'd0, wn},        {27'd0, m_wn});
      chk("d",         d,                  m_d);
      chk("busy",      busy,               m_busy());
      chk("ld_ready",  {31'd0, ld_ready},  {31'd0, m_ready()});
      chk("alu_stall", {31'd0, alu_stall}, {31'd0, m_stall()});
      chk("err",       {31'd0, err},       {31'd0, m_err});
    end
  end

  task automatic drive(input logic r, input logic aw, input logic [4:0] awn, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lwn, input logic [31:0] ldd);
    rst = r; alu_we = aw; alu_wn = awn; alu_d = ad;
    ld_valid = lv; ld_wn = lwn; ld_d = ldd;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    chk_en = 1;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    drive(1, 1, 5'd3, 32'h1234, 1, 5'd9, 32'h5678);
    tick();
    tick();
    chk("rst_we", {31'd0, we}, 32'd0);
    chk("rst_wn", {27'd0, wn}, 32'd0);
    chk("rst_d", d, 32'd0);
    chk("rst_ready", {31'd0, ld_ready}, 32'd1);
    chk("rst_busy", busy, 32'd0);
    chk("rst_stall", {31'd0, alu_stall}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);

    // Load only
    drive(0, 0, 0, 0, 1, 5'd5, 32'hDEADBEEF);
    tick();
    chk("ld_busy5_e1", {31'd0, busy[5]}, 32'd1);
    chk("ld_we_e1", {31'd0, we}, 32'd0);
    idle(1);
    chk("ld_we_e2", {31'd0, we}, 32'd1);
    chk("ld_wn_e2", {27'd0, wn}, 32'd5);
    chk("ld_d_e2", d, 32'hDEADBEEF);
    chk("ld_busy5_e2", {31'd0, busy[5]}, 32'd0);
    idle(1);
    chk("idle_we", {31'd0, we}, 32'd0);
    chk("idle_hold_d", d, 32'hDEADBEEF);

    // Collision: ALU first, load next
    drive(0, 1, 5'd3, 32'd1, 1, 5'd4, 32'd2);
    tick();
    chk("col_wn1", {27'd0, wn}, 32'd3);
    chk("col_d1", d, 32'd1);
    idle(1);
    chk("col_we2", {31'd0, we}, 32'd1);
    chk("col_wn2", {27'd0, wn}, 32'd4);
    chk("col_d2", d, 32'd2);

    // WAW kill
    drive(0, 0, 0, 0, 1, 5'd7, 32'd5);
    tick();
    chk("waw_busy7", {31'd0, busy[7]}, 32'd1);
    drive(0, 1, 5'd7, 32'd9, 0, 0, 0);
    tick();
    chk("waw_wn", {27'd0, wn}, 32'd7);
    chk("waw_d", d, 32'd9);
    chk("waw_busy7_clr", {31'd0, busy[7]}, 32'd0);
    idle(1);
    chk("waw_killed_we", {31'd0, we}, 32'd0);

    // Register 0
    drive(0, 1, 5'd0, 32'h22, 1, 5'd0, 32'h11);
    tick();
    chk("r0_we1", {31'd0, we}, 32'd0);
    chk("r0_busy", busy, 32'd0);
    idle(1);
    chk("r0_we2", {31'd0, we}, 32'd0);
    idle(1);

    // Full / starvation with ALU held busy
    do_reset();
    tick();
    for (int i = 1; i <= 6; i++) begin
      drive(0, 1, 5'd1, 32'(i), 1, 5'(9 + i), 32'(100 + i));
      tick();
      if (i == 2) chk("fs_stall_c2", {31'd0, alu_stall}, 32'd0);
      if (i == 3) begin
        chk("fs_stall_c3", {31'd0, alu_stall}, 32'd1);
        chk("fs_err_c3", {31'd0, err}, 32'd0);
      end
      if (i == 4) begin
        chk("fs_ready_c4", {31'd0, ld_ready}, 32'd0);
        chk("fs_err_c4", {31'd0, err}, 32'd1);
      end
    end
    idle(6);
    chk("fs_err_sticky", {31'd0, err}, 32'd1);
    chk("fs_drained_busy", busy, 32'd0);

    // Mid-operation reset
    do_reset();
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 5'd2, 32'(i), 1, 5'(20 + i), 32'(i));
      tick();
    end
    chk("mr_busy_pre", {31'd0, busy[21]}, 32'd1);
    drive(1, 1, 5'd6, 32'h77, 1, 5'd8, 32'h88);
    tick();
    chk("mr_ready", {31'd0, ld_ready}, 32'd1);
    chk("mr_busy", busy, 32'd0);
    chk("mr_we", {31'd0, we}, 32'd0);
    chk("mr_err", {31'd0, err}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      chk("mr_no_write", {31'd0, we}, 32'd0);
    end

    // Mixed traffic: pointer wrap, WAW hits, stall violations, occasional reset
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 60) == 0), ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
            $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      tick();
    end
    idle(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameters SHALL be: DEPTH, default 4, number of load-queue entries (power of 2, 2..16); STARVE, default 3, consecutive denied drain cycles before ALU stall.
REQ-002 The ports SHALL be, one per line:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- alu_we  in  1  ALU write-back request, single-cycle, never back-pressured
- alu_wn  in  5  ALU destination register
- alu_d  in  32  ALU result
- ld_valid  in  1  load result offered
- ld_wn  in  5  load destination register
- ld_d  in  32  load data
- ld_ready  out  1  load queue can accept
- we  out  1  register-file write enable (registered)
- wn  out  5  register-file write address (registered)
- d  out  32  register-file write data (registered)
- busy  out  32  per-register pending-load scoreboard, bit 0 always 0
- alu_stall  out  1  pipeline must withhold alu_we next cycle
- err  out  1  sticky protocol-violation flag

Function
REQ-003 A load transfer SHALL occur on a clk edge where ld_valid and ld_ready are both 1; the entry {ld_wn, ld_d, live=1} SHALL be pushed into the FIFO tail.
REQ-004 ld_ready SHALL equal "FIFO count < DEPTH"; a simultaneous push and pop when full SHALL NOT occur because ld_ready is 0 when full.
REQ-005 Arbitration SHALL be evaluated every cycle: if alu_we=1, the ALU wins; otherwise, if the FIFO is non-empty, the head entry is popped.
REQ-006 Output latency SHALL be one cycle: the winner's {wn,d} SHALL appear on the outputs at the next edge, with we=1 only if the winner's register is nonzero and, for a FIFO pop, live=1.
REQ-007 Writes to register 0 SHALL be consumed (FIFO entry popped, ALU request accepted) with we=0.
REQ-008 A popped entry with live=0 SHALL be discarded with we=0, and the pop cycle SHALL NOT be lost to the ALU.
REQ-009 WAW: when alu_we=1 with alu_wn=r≠0, every live FIFO entry targeting r SHALL be cleared to live=0 at that edge, including an entry pushed at the same edge.
REQ-010 busy[r] SHALL be 1 iff at least one live FIFO entry targets r≠0, computed combinationally from FIFO contents; it SHALL update one edge after push, pop, or kill.
REQ-011 A starvation counter SHALL increment on each cycle where the FIFO is non-empty and alu_we=1, and clear on any pop or when the FIFO is empty.
REQ-012 alu_stall SHALL be 1 while the counter ≥ STARVE or the FIFO count ≥ DEPTH-1; while alu_stall=1 and the FIFO is non-empty, the head SHALL be popped.
REQ-013 alu_we=1 while alu_stall=1 SHALL still be served by the ALU (no data loss) and SHALL set err=1 until reset.
REQ-014 The FIFO pointers SHALL wrap modulo DEPTH; the count SHALL be a separate log2(DEPTH)+1-bit counter.
REQ-015 When alu_we=0 and the FIFO is empty, the outputs SHALL be we=0, with wn and d holding their previous values.

Reset
REQ-016 While rst=1 at an edge, the block SHALL set: FIFO empty, all live bits 0, starvation counter 0, we=0, wn=0, d=0, err=0; consequently ld_ready=1, busy=0, alu_stall=0.
REQ-017 Reset during queued loads SHALL discard all pending entries with no write issued; inputs presented during reset SHALL be ignored.

Verification
REQ-018 Load only: ld_valid=1, ld_wn=5, ld_d=0xDEADBEEF, alu_we=0 -> busy[5]=1 after edge 1; we=1, wn=5, d=0xDEADBEEF after edge 2; busy[5]=0 after edge 2.
REQ-019 Collision: same-cycle alu_we=1 (wn=3, d=1) and queued load (wn=4, d=2) -> ALU write first (wn=3, d=1), load write (wn=4, d=2) next cycle.
REQ-020 WAW kill: load to r7 queued, then alu_we=1 to r7 with d=9 -> single write r7=9; the killed entry pops with we=0; busy[7] cleared.
REQ-021 Full/starve: alu_we=1 held continuously with 4 loads pushed -> ld_ready=0 at count 4, alu_stall=1 by count 3; ALU kept active -> err=1 sticky.
REQ-022 Register 0: load with ld_wn=0 and ALU with alu_wn=0 -> both consumed, we stays 0, busy stays 0.
REQ-023 Mid-operation reset: 3 entries queued, rst=1 for one edge -> ld_ready=1, busy=0, we=0, and no writes after rst drops.
